// File: rtl/wb_ram_responder.sv
// -----------------------------------------------------------------------------
// wb_ram_responder
//   Wishbone slave backed by a single-port word RAM. In-range accesses that
//   miss take a fixed number of wait cycles. After every read, the RAM
//   speculatively fetches the next word into a one-entry prefetch buffer, so
//   a sequential read that follows is acknowledged on the next cycle.
//   Out-of-range requests are acknowledged immediately with zero data.
//
// Parameters
//   DELAYS : wait cycles for a non-prefetched access (1..15)
//   DEPTH  : RAM size in 32-bit words (power of two)
//   BASE   : byte address of word 0
//
// Ports
//   wb_clk_i   : clock, rising edge
//   wb_rst_i   : synchronous active-high reset (RAM contents are kept)
//   wbs_stb_i  : strobe
//   wbs_cyc_i  : bus cycle valid
//   wbs_we_i   : 1 = write, 0 = read
//   wbs_sel_i  : byte-lane enables
//   wbs_dat_i  : write data
//   wbs_adr_i  : byte address (bits [1:0] ignored)
//   wbs_ack_o  : single-cycle transfer acknowledge (registered)
//   wbs_dat_o  : read data, forced to zero while ack is low (registered)
// -----------------------------------------------------------------------------
module wb_ram_responder #(
    parameter int unsigned DELAYS = 32'd10,
    parameter int unsigned DEPTH  = 32'd1024,
    parameter logic [31:0] BASE   = 32'h3800_0000
) (
    input  logic        wb_clk_i,
    input  logic        wb_rst_i,
    input  logic        wbs_stb_i,
    input  logic        wbs_cyc_i,
    input  logic        wbs_we_i,
    input  logic [3:0]  wbs_sel_i,
    input  logic [31:0] wbs_dat_i,
    input  logic [31:0] wbs_adr_i,
    output logic        wbs_ack_o,
    output logic [31:0] wbs_dat_o
);

    localparam int unsigned AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_ACK  = 2'd2,
        S_PREF = 2'd3
    } state_t;

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;
    logic [AW-1:0]   idx_q, idx_d;
    logic            we_q, we_d;
    logic            oor_q, oor_d;
    logic            ack_q, ack_d;
    logic [31:0]     dat_q, dat_d;
    logic            pvalid_q, pvalid_d;
    logic [AW-1:0]   ptag_q, ptag_d;
    logic [31:0]     pbuf_q, pbuf_d;

    logic [31:0]     mem_q [DEPTH];

    logic            req_s;
    logic [31:0]     off_s;
    logic            in_range_s;
    logic [AW-1:0]   req_idx_s;
    logic [AW-1:0]   idx_nxt_s;
    logic            mem_we_s;
    logic            unused_s;

    // Address decode: the offset from BASE must be non-negative and below
    // 4*DEPTH; testing the offset's upper bits avoids overflow of BASE+4*DEPTH.
    always_comb begin
        req_s      = wbs_cyc_i & wbs_stb_i;
        off_s      = wbs_adr_i - BASE;
        in_range_s = (wbs_adr_i >= BASE) && (off_s[31:AW+2] == '0);
        req_idx_s  = off_s[AW+1:2];
        // Word index wraps naturally because DEPTH is a power of two.
        idx_nxt_s  = idx_q + {{(AW-1){1'b0}}, 1'b1};
        unused_s   = ^off_s[1:0];
    end

    // Next-state, datapath and output decode for the transfer FSM.
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        idx_d    = idx_q;
        we_d     = we_q;
        oor_d    = oor_q;
        ack_d    = 1'b0;
        dat_d    = 32'h0000_0000;
        pvalid_d = pvalid_q;
        ptag_d   = ptag_q;
        pbuf_d   = pbuf_q;
        mem_we_s = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (req_s) begin
                    idx_d = req_idx_s;
                    we_d  = wbs_we_i;
                    oor_d = ~in_range_s;
                    if (!in_range_s) begin
                        state_d = S_ACK;
                        ack_d   = 1'b1;
                        dat_d   = 32'h0000_0000;
                    end else if (!wbs_we_i && pvalid_q && (req_idx_s == ptag_q)) begin
                        state_d = S_ACK;
                        ack_d   = 1'b1;
                        dat_d   = pbuf_q;
                    end else begin
                        state_d = S_WAIT;
                        cnt_d   = 4'(DELAYS);
                    end
                end else begin
                    state_d = S_IDLE;
                end
            end

            S_WAIT: begin
                if (!req_s) begin
                    // Master gave up: drop the transfer without touching RAM.
                    state_d = S_IDLE;
                    cnt_d   = 4'd0;
                end else if (cnt_q <= 4'd1) begin
                    // Leaving on the count that would reach zero makes the
                    // ack land DELAYS+1 cycles after the request.
                    state_d = S_ACK;
                    cnt_d   = 4'd0;
                    ack_d   = 1'b1;
                    dat_d   = we_q ? 32'h0000_0000 : mem_q[idx_q];
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end

            S_ACK: begin
                if (oor_q) begin
                    state_d = S_IDLE;
                end else if (we_q) begin
                    state_d  = S_IDLE;
                    mem_we_s = ~wb_rst_i;
                    if (idx_q == ptag_q) begin
                        pvalid_d = 1'b0;
                    end else begin
                        pvalid_d = pvalid_q;
                    end
                end else begin
                    state_d = S_PREF;
                end
            end

            S_PREF: begin
                state_d  = S_IDLE;
                pbuf_d   = mem_q[idx_nxt_s];
                ptag_d   = idx_nxt_s;
                pvalid_d = 1'b1;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= 4'd0;
            idx_q    <= '0;
            we_q     <= 1'b0;
            oor_q    <= 1'b0;
            ack_q    <= 1'b0;
            dat_q    <= 32'h0000_0000;
            pvalid_q <= 1'b0;
            ptag_q   <= '0;
            pbuf_q   <= 32'h0000_0000;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            idx_q    <= idx_d;
            we_q     <= we_d;
            oor_q    <= oor_d;
            ack_q    <= ack_d;
            dat_q    <= dat_d;
            pvalid_q <= pvalid_d;
            ptag_q   <= ptag_d;
            pbuf_q   <= pbuf_d;
        end
    end

    // Byte-lane RAM write at the end of a write acknowledge; no reset so
    // contents survive wb_rst_i.
    always_ff @(posedge wb_clk_i) begin
        if (mem_we_s) begin
            for (int b = 0; b < 4; b++) begin
                if (wbs_sel_i[b]) begin
                    mem_q[idx_q][8*b +: 8] <= wbs_dat_i[8*b +: 8];
                end
            end
        end
    end

    assign wbs_ack_o = ack_q;
    assign wbs_dat_o = dat_q;

endmodule

// File: tb/tb_wb_ram_responder.sv
module tb_wb_ram_responder;

    localparam int          D     = 10;
    localparam int          DEPTH = 1024;
    localparam logic [31:0] BASE  = 32'h3800_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        stb, cyc, we;
    logic [3:0]  sel;
    logic [31:0] wdat, adr;
    logic        ack;
    logic [31:0] rdat;

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model state: known RAM words and the prefetch entry.
    logic [31:0] mdl_mem [int];
    bit          mdl_pv = 1'b0;
    int          mdl_pt = 0;

    always #5 clk = ~clk;

    wb_ram_responder #(
        .DELAYS (D),
        .DEPTH  (DEPTH),
        .BASE   (BASE)
    ) dut (
        .wb_clk_i  (clk),
        .wb_rst_i  (rst),
        .wbs_stb_i (stb),
        .wbs_cyc_i (cyc),
        .wbs_we_i  (we),
        .wbs_sel_i (sel),
        .wbs_dat_i (wdat),
        .wbs_adr_i (adr),
        .wbs_ack_o (ack),
        .wbs_dat_o (rdat)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=0x%08h exp=0x%08h", tag, got, exp);
        end
    endtask

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] nw,
                                          input logic [3:0] s);
        logic [31:0] r;
        r = old;
        for (int b = 0; b < 4; b++) if (s[b]) r[8*b +: 8] = nw[8*b +: 8];
        return r;
    endfunction

    // Expected behaviour of one complete transfer, updating model state.
    task automatic model(input bit w, input logic [3:0] s, input logic [31:0] a,
                         input logic [31:0] d, output int lat, output bit dchk,
                         output logic [31:0] edat);
        longint la, lb;
        int     idx;
        la   = longint'(a);
        lb   = longint'(BASE);
        dchk = 1'b0;
        edat = 32'h0;
        if (la < lb || la >= lb + 4 * DEPTH) begin
            lat  = 1;
            dchk = !w;
        end else begin
            idx = int'((la - lb) / 4);
            if (!w) begin
                lat  = (mdl_pv && mdl_pt == idx) ? 1 : D + 1;
                dchk = mdl_mem.exists(idx);
                if (dchk) edat = mdl_mem[idx];
                mdl_pv = 1'b1;
                mdl_pt = (idx + 1) % DEPTH;
            end else begin
                lat = D + 1;
                if (mdl_mem.exists(idx)) mdl_mem[idx] = merge(mdl_mem[idx], d, s);
                else if (s == 4'hF) mdl_mem[idx] = d;
                if (idx == mdl_pt) mdl_pv = 1'b0;
            end
        end
    endtask

    // Drive one transfer starting in an idle cycle; measure ack latency.
    task automatic bus(input bit w, input logic [3:0] s, input logic [31:0] a,
                       input logic [31:0] d, output int lat, output logic [31:0] rd);
        bit got;
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = w; sel = s; adr = a; wdat = d;
        lat = 0; got = 1'b0; rd = 32'h0;
        while (!got && lat < 40) begin
            @(posedge clk); #1;
            lat++;
            if (ack) begin
                got = 1'b1;
                rd  = rdat;
            end else begin
                check("dat_zero_no_ack", rdat, 32'h0);
            end
        end
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(posedge clk); #1;
        check("ack_one_cycle", {31'h0, ack}, 32'h0);
    endtask

    task automatic xfer(input string tag, input bit w, input logic [3:0] s,
                        input logic [31:0] a, input logic [31:0] d, output logic [31:0] rd);
        int          elat, lat;
        bit          dchk;
        logic [31:0] edat;
        model(w, s, a, d, elat, dchk, edat);
        bus(w, s, a, d, lat, rd);
        check({tag, "_lat"}, 32'(lat), 32'(elat));
        if (dchk) check({tag, "_dat"}, rd, edat);
    endtask

    function automatic logic [31:0] wa(input int idx);
        return BASE + 32'(idx * 4);
    endfunction

    logic [31:0] rd;
    int          idx, r;

    initial begin
        rst = 1'b1; cyc = 1'b0; stb = 1'b0; we = 1'b0;
        sel = 4'h0; wdat = 32'h0; adr = 32'h0;
        repeat (3) @(posedge clk);
        #1;
        check("rst_ack", {31'h0, ack}, 32'h0);
        check("rst_dat", rdat, 32'h0);
        rst = 1'b0;

        // Initialise a working window of words with full writes.
        for (int i = 0; i < 20; i++) begin
            idx = (i < 16) ? i : 1004 + i;
            xfer("init", 1'b1, 4'hF, wa(idx), $urandom, rd);
        end
        xfer("init64", 1'b1, 4'hF, wa(64), 32'h6464_6464, rd);

        // Basic write/read, sequential hit, miss elsewhere.
        xfer("wr10", 1'b1, 4'hF, 32'h3800_0010, 32'hDEAD_BEEF, rd);
        xfer("rd10", 1'b0, 4'hF, 32'h3800_0010, 32'h0, rd);
        check("rd10_const", rd, 32'hDEAD_BEEF);
        xfer("rd14_hit", 1'b0, 4'hF, 32'h3800_0014, 32'h0, rd);
        xfer("rd100_miss", 1'b0, 4'hF, 32'h3800_0100, 32'h0, rd);

        // Byte-lane merge and prefetch invalidation by a write.
        xfer("wr08", 1'b1, 4'hF, 32'h3800_0008, 32'h1122_3344, rd);
        xfer("wr08_sel", 1'b1, 4'b0101, 32'h3800_0008, 32'hAABB_CCDD, rd);
        xfer("rd08", 1'b0, 4'hF, 32'h3800_0008, 32'h0, rd);
        check("rd08_const", rd, 32'h11BB_33DD);
        xfer("wr0c_inv", 1'b1, 4'hF, 32'h3800_000C, 32'hCAFE_F00D, rd);
        xfer("rd0c_miss", 1'b0, 4'hF, 32'h3800_000C, 32'h0, rd);
        check("rd0c_const", rd, 32'hCAFE_F00D);
        xfer("wr_sel0", 1'b1, 4'h0, 32'h3800_000C, 32'h0000_0000, rd);
        xfer("rd_sel0", 1'b0, 4'hF, 32'h3800_000C, 32'h0, rd);

        // Wrap of the prefetch index, out-of-range access.
        xfer("rd_ffc", 1'b0, 4'hF, 32'h3800_0FFC, 32'h0, rd);
        xfer("rd_000_wrap", 1'b0, 4'hF, 32'h3800_0000, 32'h0, rd);
        xfer("oor_rd", 1'b0, 4'hF, 32'h3800_1000, 32'h0, rd);
        xfer("oor_wr", 1'b1, 4'hF, 32'h3800_1000, 32'hFFFF_FFFF, rd);
        xfer("oor_below", 1'b1, 4'hF, 32'h37FF_FFFC, 32'hFFFF_FFFF, rd);
        xfer("rd_000_kept", 1'b0, 4'hF, 32'h3800_0000, 32'h0, rd);
        xfer("rd_ffc_kept", 1'b0, 4'hF, 32'h3800_0FFC, 32'h0, rd);

        // Write miss aborted by dropping strobe in cycle 5.
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b1; sel = 4'hF; adr = wa(4); wdat = 32'h0BAD_0BAD;
        for (int i = 0; i < 5; i++) begin
            @(posedge clk); #1;
            check("abort_pre_ack", {31'h0, ack}, 32'h0);
        end
        stb = 1'b0; cyc = 1'b0; we = 1'b0;
        for (int i = 0; i < 15; i++) begin
            @(posedge clk); #1;
            check("abort_no_ack", {31'h0, ack}, 32'h0);
        end
        xfer("abort_rd", 1'b0, 4'hF, wa(4), 32'h0, rd);

        // Reset in cycle 4 of a read miss kills it and the prefetch entry.
        xfer("pre_rst_rd", 1'b0, 4'hF, wa(8), 32'h0, rd);
        @(posedge clk); #1;
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = wa(12);
        repeat (4) @(posedge clk);
        #1;
        rst = 1'b1; cyc = 1'b0; stb = 1'b0;
        @(posedge clk); #1;
        check("rst_mid_ack", {31'h0, ack}, 32'h0);
        check("rst_mid_dat", rdat, 32'h0);
        rst = 1'b0;
        mdl_pv = 1'b0; mdl_pt = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            check("rst_no_late_ack", {31'h0, ack}, 32'h0);
        end
        xfer("post_rst_miss", 1'b0, 4'hF, wa(9), 32'h0, rd);

        // Reset dominates a simultaneous request.
        @(posedge clk); #1;
        rst = 1'b1; cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h3800_1000;
        @(posedge clk); #1;
        rst = 1'b0; cyc = 1'b0; stb = 1'b0;
        check("rst_dom_ack0", {31'h0, ack}, 32'h0);
        @(posedge clk); #1;
        check("rst_dom_ack1", {31'h0, ack}, 32'h0);
        mdl_pv = 1'b0; mdl_pt = 0;

        // Randomized traffic against the model.
        for (int i = 0; i < 80; i++) begin
            r = $urandom_range(0, 9);
            if (r < 5 || (r < 8 && !mdl_pv)) begin
                idx = $urandom_range(0, 19);
                if (idx >= 16) idx = 1004 + idx;
                adr = wa(idx) + 32'($urandom_range(0, 3));
            end else if (r < 8) begin
                adr = wa(mdl_pt) + 32'($urandom_range(0, 3));
            end else begin
                case ($urandom_range(0, 2))
                    0:       adr = BASE - 32'd4;
                    1:       adr = BASE + 32'(4 * DEPTH) + 32'($urandom_range(0, 3));
                    default: adr = $urandom;
                endcase
            end
            xfer("rand", ($urandom_range(0, 2) == 0), 4'($urandom), adr, $urandom, rd);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/wb_ram_responder.md
WB_RAM_RESPONDER -- requirements
Module: wb_ram_responder

Interface
REQ-001 SHALL provide parameter DELAYS, default 10, wait cycles for a non-prefetched access (legal 1..15).
REQ-002 SHALL provide parameter DEPTH, default 1024, memory size in 32-bit words (power of two).
REQ-003 SHALL provide parameter BASE, default 32'h3800_0000, byte address of word 0.
REQ-004 wb_clk_i  input  1  single clock; all logic on its rising edge.
REQ-005 wb_rst_i  input  1  reset, synchronous, active-high.
REQ-006 wbs_stb_i  input  1  strobe from arbiter.
REQ-007 wbs_cyc_i  input  1  bus cycle valid.
REQ-008 wbs_we_i  input  1  1=write, 0=read.
REQ-009 wbs_sel_i  input  4  byte enables, bit n = dat[8n+7:8n].
REQ-010 wbs_dat_i  input  32  write data.
REQ-011 wbs_adr_i  input  32  byte address.
REQ-012 wbs_ack_o  output  1  one-cycle transfer acknowledge.
REQ-013 wbs_dat_o  output  32  read data, valid only while ack=1.

Function
REQ-014 Request = cyc & stb, sampled only in IDLE; in-range = BASE <= adr < BASE+4*DEPTH; word index idx = (adr-BASE)>>2; adr[1:0] ignored.
REQ-015 FSM states IDLE, WAIT, ACK, PREF; at most one transaction in flight.
REQ-016 IDLE: out-of-range request -> ACK next cycle, dat_o=0, no write; in-range read with prefetch hit (pvalid & idx==ptag) -> ACK next cycle; any other in-range request -> WAIT with counter loaded to DELAYS.
REQ-017 WAIT: counter decrements each cycle; at zero -> ACK; miss latency = request cycle to ack cycle = DELAYS+1 cycles; hit/out-of-range latency = 1 cycle.
REQ-018 WAIT: cyc or stb low in any cycle -> abort to IDLE, no ack, no memory write.
REQ-019 ACK: ack=1 exactly one cycle; read returns mem[idx] (hit: pbuf); write updates only lanes with sel=1 in this cycle; sel=0000 write acks with no change.
REQ-020 After a read ack -> PREF (one cycle): pbuf <= mem[(idx+1) mod DEPTH], ptag <= (idx+1) mod DEPTH, pvalid <= 1; index DEPTH-1 wraps to 0; then IDLE.
REQ-021 After a write ack or out-of-range ack -> IDLE, no prefetch.
REQ-022 Write ack with idx==ptag SHALL clear pvalid in the same cycle; writes to other indices leave prefetch intact.
REQ-023 Requests arriving in ACK or PREF are not sampled; they are accepted on the first IDLE cycle (stb still high after ack is treated as a new request).
REQ-024 dat_o SHALL be 0 whenever ack=0.
REQ-025 Memory is single-port, one access per cycle; a prefetch never coincides with a master access.

Reset
REQ-026 On wb_rst_i=1 at a clock edge: state IDLE, ack=0, dat_o=0, counter=0, pvalid=0, ptag=0, pbuf=0; memory contents unchanged.
REQ-027 Reset during WAIT/ACK/PREF aborts the transaction: no ack in the cycle after reset, pending write not performed.
REQ-028 Reset dominates any simultaneous request.

Verification
REQ-029 Write 0xDEADBEEF sel=1111 to 0x3800_0010, DELAYS=10 -> ack exactly 11 cycles after request, one cycle wide; read 0x3800_0010 -> ack at +11, dat_o=0xDEADBEEF.
REQ-030 After reading 0x3800_0010, read 0x3800_0014 -> hit, ack 1 cycle after request; then read 0x3800_0100 -> miss, ack at +11.
REQ-031 Word = 0x11223344, write 0xAABBCCDD sel=0101 -> readback 0x11BB33DD; write to the prefetched index -> following read is a miss (+11) and returns new data.
REQ-032 Read 0x3800_0FFC (idx 1023) then 0x3800_0000 -> second read hits (wrap); read 0x3800_1000 -> ack at +1, dat_o=0, memory unchanged.
REQ-033 Drop stb at cycle 5 of a write miss -> no ack, memory unchanged; assert reset at cycle 4 of a read miss -> no ack, pvalid=0, next read of prefetched address is a miss.
